// File: rtl/lock_pkg.sv
// lock_pkg
// Shared types and constants for the three-step combination lock.
//   lock_state_e : controller state (ARMED carries a separate step count)
//   SEG_*        : 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   UIO_OE_VAL   : bidirectional pad direction (low nibble driven)
//   seg_for()    : display pattern for a given state/step
package lock_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } lock_state_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_U = 7'h3E;
    localparam logic [6:0] SEG_L = 7'h38;

    localparam logic [7:0] UIO_OE_VAL = 8'h0F;

    function automatic logic [6:0] seg_for(input lock_state_e st, input logic [1:0] step);
        logic [6:0] seg;
        seg = SEG_0;
        case (st)
            ST_OPEN:    seg = SEG_U;
            ST_LOCKOUT: seg = SEG_L;
            default: begin
                case (step)
                    2'd1:    seg = SEG_1;
                    2'd2:    seg = SEG_2;
                    default: seg = SEG_0;
                endcase
            end
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
// Two-flop synchronizer for an asynchronous input bus plus a registered
// one-cycle rising-edge pulse on the top bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   async_in   : raw asynchronous inputs
//   sync_out   : synchronized copy (two clocks of latency)
//   rise_p     : one-cycle pulse, high on the 2nd edge after async_in[MSB]
//                is first sampled high
module sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic             rise_p
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [1:0]       fill_q, fill_d;
    logic             prev_q, prev_d;
    logic             rise_q, rise_d;
    logic             valid;

    // fill_q marks when sync_q holds genuine samples rather than reset zeros.
    // Until then prev_q is held high, so a button already held through reset
    // release must be seen low before any edge can be reported.
    assign valid = fill_q[1];

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        fill_d = {fill_q[0], 1'b1};
        prev_d = valid ? sync_q[WIDTH-1] : 1'b1;
        rise_d = valid & sync_q[WIDTH-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            fill_q <= '0;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            fill_q <= fill_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign sync_out = sync_q;
    assign rise_p   = rise_q;

endmodule

// File: rtl/tt_um_combo_lock_ctrl.sv
// tt_um_combo_lock_ctrl
// Three-step combination lock at TinyTapeout tile level.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : tile enable (ignored)
//   ui_in      : [6:0] code switches, [7] ENTER button (asynchronous)
//   uio_in     : unused
//   uo_out     : [6:0] segments a..g, [7] UNLOCK
//   uio_out    : [1:0] fail count, [2] lockout, [3] enter pulse, [7:4] 0
//   uio_oe     : constant 8'h0F
module tt_um_combo_lock_ctrl
    import lock_pkg::*;
#(
    parameter logic [6:0] CODE0       = 7'h42,
    parameter logic [6:0] CODE1       = 7'h24,
    parameter logic [6:0] CODE2       = 7'h18,
    parameter int         CNT_W       = 24,
    parameter int         OPEN_CYCLES = 10_000_000,
    parameter int         LOCK_CYCLES = 30_000_000,
    parameter int         MAX_FAILS   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // The timer is widened beyond CNT_W when needed so the default lockout
    // count (30M) still fits without truncation.
    localparam int MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = (CNT_W > $clog2(MAX_CYC)) ? CNT_W : $clog2(MAX_CYC);

    localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [1:0]       FAIL_LIM  = 2'(MAX_FAILS);

    logic [7:0] sync_ui;
    logic       enter_p;

    sync_edge #(.WIDTH(8)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ui_in),
        .sync_out (sync_ui),
        .rise_p   (enter_p)
    );

    lock_state_e      state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [1:0]       fail_q, fail_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [6:0]       seg_q, seg_d;
    logic             unlock_q, unlock_d;
    logic             lockout_q, lockout_d;

    logic [6:0] code_exp;
    logic [1:0] fail_inc;

    always_comb begin
        case (step_q)
            2'd0:    code_exp = CODE0;
            2'd1:    code_exp = CODE1;
            default: code_exp = CODE2;
        endcase
    end

    assign fail_inc = fail_q + 2'd1;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        fail_d  = fail_q;
        timer_d = timer_q;

        case (state_q)
            ST_ARMED: begin
                if (enter_p) begin
                    if (sync_ui[6:0] == code_exp) begin
                        if (step_q == 2'd2) begin
                            state_d = ST_OPEN;
                            step_d  = 2'd0;
                            timer_d = OPEN_LOAD;
                            fail_d  = 2'd0;
                        end else begin
                            step_d = step_q + 2'd1;
                        end
                    end else begin
                        step_d = 2'd0;
                        if (fail_inc == FAIL_LIM) begin
                            state_d = ST_LOCKOUT;
                            timer_d = LOCK_LOAD;
                            fail_d  = 2'd0;
                        end else begin
                            fail_d = fail_inc;
                        end
                    end
                end
            end

            ST_OPEN: begin
                if (enter_p || timer_q == '0) begin
                    state_d = ST_ARMED;
                    step_d  = 2'd0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end

            ST_LOCKOUT: begin
                // enter_p deliberately ignored here
                if (timer_q == '0) begin
                    state_d = ST_ARMED;
                    step_d  = 2'd0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end

            default: begin
                state_d = ST_ARMED;
                step_d  = 2'd0;
                fail_d  = 2'd0;
                timer_d = '0;
            end
        endcase

        // Display and status come from the next state so they move with it.
        seg_d     = seg_for(state_d, step_d);
        unlock_d  = (state_d == ST_OPEN);
        lockout_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARMED;
            step_q    <= 2'd0;
            fail_q    <= 2'd0;
            timer_q   <= '0;
            seg_q     <= SEG_0;
            unlock_q  <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            fail_q    <= fail_d;
            timer_q   <= timer_d;
            seg_q     <= seg_d;
            unlock_q  <= unlock_d;
            lockout_q <= lockout_d;
        end
    end

    assign uo_out  = {unlock_q, seg_q};
    assign uio_out = {4'b0000, enter_p, lockout_q, fail_q};
    assign uio_oe  = UIO_OE_VAL;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, sync_ui[7]};

endmodule

// File: tb/tb_tt_um_combo_lock_ctrl.sv
module tb_tt_um_combo_lock_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total_cnt;
    int bad_cnt;
    int cyc;

    tt_um_combo_lock_ctrl #(
        .OPEN_CYCLES (8),
        .LOCK_CYCLES (16),
        .MAX_FAILS   (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a code, then press ENTER; returns 1ns after the edge where the
    // state has taken the entry (3 edges after ENTER is first sampled).
    task automatic applyStimulus(input logic [6:0] code);
        @(negedge clk);
        ui_in = {1'b0, code};
        repeat (3) @(negedge clk);
        ui_in[7] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ui_in[7] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Counts clocks UNLOCK stays high, starting from the entry edge.
    task automatic countOpen(output int n);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (uo_out[7]) n++;
            else break;
        end
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        ui_in     = 8'h00;
        uio_in    = 8'h00;

        #12;
        checkOutput("rst_uo", uo_out, 8'h3F);
        checkOutput("rst_uio", uio_out, 8'h00);
        checkOutput("uio_oe", uio_oe, 8'h0F);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Correct sequence, then OPEN duration
        applyStimulus(7'h42);
        checkOutput("seq_step1", uo_out, 8'h06);
        applyStimulus(7'h24);
        checkOutput("seq_step2", uo_out, 8'h5B);
        applyStimulus(7'h18);
        checkOutput("seq_open", uo_out, 8'hBE);
        countOpen(cyc);
        checkOutput("open_len", cyc, 8);
        checkOutput("open_end", uo_out, 8'h3F);

        // One wrong entry, then a correct sequence clears the fail count
        applyStimulus(7'h42);
        checkOutput("wr_step1", uo_out, 8'h06);
        applyStimulus(7'h00);
        checkOutput("wr_uo", uo_out, 8'h3F);
        checkOutput("wr_fail1", uio_out, 8'h01);
        applyStimulus(7'h42);
        applyStimulus(7'h24);
        applyStimulus(7'h18);
        checkOutput("wr_open", uo_out, 8'hBE);
        checkOutput("wr_fail0", uio_out, 8'h00);

        // Asynchronous reset in the middle of OPEN
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_uo", uo_out, 8'h3F);
        checkOutput("midrst_uio", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postrst_uo", uo_out, 8'h3F);
        repeat (3) @(negedge clk);
        applyStimulus(7'h42);
        checkOutput("postrst_step1", uo_out, 8'h06);
        doReset();

        // Three wrong entries trigger lockout
        applyStimulus(7'h11);
        checkOutput("lk_fail1", uio_out, 8'h01);
        applyStimulus(7'h00);
        checkOutput("lk_fail2", uio_out, 8'h02);
        applyStimulus(7'h7F);
        checkOutput("lk_uo", uo_out, 8'h38);
        checkOutput("lk_uio", uio_out, 8'h04);
        cyc = 1;
        ui_in = {1'b0, 7'h42};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ui_in[7] = (i == 1 || i == 2);
            @(posedge clk);
            #1;
            if (uo_out == 8'h38 && uio_out[2]) cyc++;
            else break;
        end
        checkOutput("lk_len", cyc, 16);
        checkOutput("lk_end_uo", uo_out, 8'h3F);
        checkOutput("lk_end_uio", uio_out, 8'h00);

        // ENTER during OPEN relocks on the 3rd clock after the press
        applyStimulus(7'h42);
        applyStimulus(7'h24);
        applyStimulus(7'h18);
        checkOutput("er_open", uo_out, 8'hBE);
        @(negedge clk);
        ui_in[7] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("er_k0", uo_out[7], 1'b1);
        @(negedge clk);
        ui_in[7] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("er_k1", uo_out[7], 1'b1);
        @(posedge clk);
        #1;
        checkOutput("er_k2", uo_out[7], 1'b1);
        checkOutput("er_pulse", uio_out[3], 1'b1);
        @(posedge clk);
        #1;
        checkOutput("er_k3", uo_out, 8'h3F);

        // ENTER held high across reset release gives no step advance
        @(negedge clk);
        rst_n = 1'b0;
        ui_in = {1'b1, 7'h42};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("held_uo", uo_out, 8'h3F);
        checkOutput("held_uio", uio_out, 8'h00);
        ui_in[7] = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(7'h42);
        checkOutput("held_after", uo_out, 8'h06);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
